// File: rtl/bcd_addsub_seq.sv
`timescale 1ns/1ps
// Digit-serial packed-BCD adder/subtractor. It resolves one digit per clock, least
// significant digit first, and publishes result/cout/zero/invalid only on completion.
module bcd_addsub_seq #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  sub,
  input  logic                  cin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   result,
  output logic                  cout,
  output logic                  zero,
  output logic                  invalid
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_n;
  logic [W-1:0]   a_q, b_q, acc_q, acc_n;
  logic [IW-1:0]  idx_q;
  logic           sub_q, c_q, inv_q;
  logic           accept, last;
  logic [3:0]     a_i, b_i, nb, digit;
  logic [4:0]     t;
  logic           c_n, dig_inv;

  // Handshake: start is sampled only while busy=0 (IDLE or DONE); operands are
  // latched on acceptance, and done pulses for the single cycle spent in DONE.
  assign accept = start && (state != RUN);
  assign last   = (idx_q == LAST);
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (last)  state_n = DONE;
      DONE:    state_n = start ? RUN : IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Current digit sits in the low nibble of the shifting operand registers.
  always_comb begin
    a_i = a_q[3:0];
    b_i = b_q[3:0];
    nb  = sub_q ? (4'd9 - b_i) : b_i;
    t   = {1'b0, a_i} + {1'b0, nb} + {4'b0, c_q};
    if (t >= 5'd10) begin
      digit = t[3:0] + 4'd6;
      c_n   = 1'b1;
    end else begin
      digit = t[3:0];
      c_n   = 1'b0;
    end
    dig_inv = (a_i > 4'd9) || (b_i > 4'd9);
    acc_n   = W'({digit, acc_q} >> 4);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      sub_q   <= 1'b0;
      c_q     <= 1'b0;
      inv_q   <= 1'b0;
      result  <= '0;
      cout    <= 1'b0;
      zero    <= 1'b1;
      invalid <= 1'b0;
    end else if (accept) begin
      a_q   <= a;
      b_q   <= b;
      sub_q <= sub;
      c_q   <= cin;
      idx_q <= '0;
      inv_q <= 1'b0;
      acc_q <= '0;
    end else if (state == RUN) begin
      a_q   <= a_q >> 4;
      b_q   <= b_q >> 4;
      c_q   <= c_n;
      idx_q <= idx_q + IW'(1);
      inv_q <= inv_q | dig_inv;
      acc_q <= acc_n;
      // Visible outputs move only with the final digit, never mid-operation.
      if (last) begin
        result  <= acc_n;
        cout    <= c_n;
        zero    <= (acc_n == '0);
        invalid <= inv_q | dig_inv;
      end
    end
  end

endmodule

// File: tb/tb_bcd_addsub_seq.sv
`timescale 1ns/1ps
// Self-checking bench for bcd_addsub_seq: directed cases, handshake corner cases,
// and random operations against a decimal reference model for DIGITS = 4, 1, 2, 16.
module tb_bcd_addsub_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, sub, cin;
  logic [15:0] a, b;
  logic        busy, done, cout, zero, invalid;
  logic [15:0] result;
  logic        sweep_go = 1'b0;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  bcd_addsub_seq #(.DIGITS(4)) u_dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .sub(sub), .cin(cin),
    .busy(busy), .done(done), .result(result), .cout(cout), .zero(zero),
    .invalid(invalid)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: plain decimal integer arithmetic.
  function automatic longint bcd2int(input logic [63:0] v, input int d);
    longint r = 0;
    for (int i = d - 1; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [63:0] int2bcd(input longint v, input int d);
    logic [63:0] r = '0;
    longint x = v;
    for (int i = 0; i < d; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic void ref_op(input logic [63:0] av, input logic [63:0] bv, input logic s,
                                 input logic ci, input int d,
                                 output logic [63:0] r, output logic co);
    longint m = 1;
    longint x;
    for (int i = 0; i < d; i++) m = m * 10;
    if (!s) begin
      x  = bcd2int(av, d) + bcd2int(bv, d) + longint'(ci);
      co = (x >= m);
      if (co) x = x - m;
    end else begin
      x  = bcd2int(av, d) - bcd2int(bv, d) - (ci ? 64'sd0 : 64'sd1);
      co = (x >= 0);
      if (!co) x = x + m;
    end
    r = int2bcd(x, d);
  endfunction

  function automatic logic [63:0] rand_bcd(input int d);
    logic [63:0] r = '0;
    for (int i = 0; i < d; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  // Drives one DIGITS=4 operation; poke re-asserts start with new operands mid-RUN.
  task automatic run4(input logic [15:0] av, input logic [15:0] bv, input logic s,
                      input logic ci, input bit poke, output int cyc);
    @(negedge clk);
    a = av; b = bv; sub = s; cin = ci; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (poke && cyc == 1) begin
        start = 1'b1; a = 16'h9999; b = 16'h8888; sub = ~s; cin = ~ci;
      end else if (poke && cyc == 2) begin
        start = 1'b0;
      end
    end while (!done && cyc < 40);
  endtask

  task automatic dir4(input string tag, input logic [15:0] av, input logic [15:0] bv,
                      input logic s, input logic ci, input logic [15:0] er,
                      input logic ec, input logic ez, input logic ei);
    int cyc;
    run4(av, bv, s, ci, 1'b0, cyc);
    check({tag, ".latency"}, cyc, 4);
    check({tag, ".result"}, result, er);
    check({tag, ".cout"}, cout, ec);
    check({tag, ".zero"}, zero, ez);
    check({tag, ".invalid"}, invalid, ei);
  endtask

  // Parameter sweep instances, released once the DIGITS=4 checks are finished.
  for (genvar g = 0; g < 3; g++) begin : sw
    localparam int D = (g == 0) ? 1 : (g == 1) ? 2 : 16;
    logic           s_start, s_sub, s_cin, s_busy, s_done, s_cout, s_zero, s_invalid;
    logic [4*D-1:0] s_a, s_b, s_result;
    logic           fin;

    bcd_addsub_seq #(.DIGITS(D)) u_dut (
      .clk(clk), .rst(rst), .start(s_start), .a(s_a), .b(s_b), .sub(s_sub),
      .cin(s_cin), .busy(s_busy), .done(s_done), .result(s_result), .cout(s_cout),
      .zero(s_zero), .invalid(s_invalid)
    );

    initial begin
      logic [63:0] av, bv, er;
      logic        sv, cv, ec;
      int          cyc;
      fin = 1'b0; s_start = 1'b0; s_a = '0; s_b = '0; s_sub = 1'b0; s_cin = 1'b0;
      wait (sweep_go);
      for (int n = 0; n < 15; n++) begin
        av = rand_bcd(D); bv = rand_bcd(D);
        sv = 1'($urandom_range(0, 1)); cv = 1'($urandom_range(0, 1));
        ref_op(av, bv, sv, cv, D, er, ec);
        @(negedge clk);
        s_a = av[4*D-1:0]; s_b = bv[4*D-1:0]; s_sub = sv; s_cin = cv; s_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s_start = 1'b0;
        cyc = 0;
        do begin
          @(negedge clk);
          cyc++;
        end while (!s_done && cyc < 60);
        check($sformatf("sweep%0d.latency", D), cyc, D);
        check($sformatf("sweep%0d.result", D), s_result, er);
        check($sformatf("sweep%0d.cout", D), s_cout, ec);
        check($sformatf("sweep%0d.zero", D), s_zero, (er == 0));
        check($sformatf("sweep%0d.invalid", D), s_invalid, 0);
      end
      fin = 1'b1;
    end
  end

  initial begin
    int          cyc, dones, guard;
    logic [63:0] er;
    logic        ec;
    logic [15:0] av, bv;
    logic        sv, cv;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; sub = 1'b0; cin = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset.busy", busy, 0);
    check("reset.done", done, 0);
    check("reset.result", result, 0);
    check("reset.cout", cout, 0);
    check("reset.zero", zero, 1);
    check("reset.invalid", invalid, 0);

    dir4("add",      16'h1234, 16'h5678, 1'b0, 1'b0, 16'h6912, 1'b0, 1'b0, 1'b0);
    dir4("add_ovf",  16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
    dir4("add_cin",  16'h9999, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0);
    dir4("sub",      16'h0100, 16'h0001, 1'b1, 1'b1, 16'h0099, 1'b1, 1'b0, 1'b0);
    dir4("sub_unf",  16'h0000, 16'h0001, 1'b1, 1'b1, 16'h9999, 1'b0, 1'b0, 1'b0);
    dir4("sub_brw",  16'h0050, 16'h0020, 1'b1, 1'b0, 16'h0029, 1'b1, 1'b0, 1'b0);
    dir4("invalid",  16'h00A0, 16'h0000, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b1);
    dir4("inv_clr",  16'h0005, 16'h0004, 1'b0, 1'b0, 16'h0009, 1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 20; n++) begin
      av = 16'(rand_bcd(4)); bv = 16'(rand_bcd(4));
      sv = 1'($urandom_range(0, 1)); cv = 1'($urandom_range(0, 1));
      ref_op(64'(av), 64'(bv), sv, cv, 4, er, ec);
      run4(av, bv, sv, cv, 1'b0, cyc);
      check("rand.latency", cyc, 4);
      check("rand.result", result, er);
      check("rand.cout", cout, ec);
      check("rand.zero", zero, (er == 0));
    end

    // start re-pulsed mid-RUN must be ignored.
    run4(16'h1234, 16'h5678, 1'b0, 1'b0, 1'b1, cyc);
    check("poke.latency", cyc, 4);
    check("poke.result", result, 16'h6912);
    check("poke.cout", cout, 0);
    @(negedge clk);
    check("poke.idle", busy, 0);

    // start held through DONE: next done exactly DIGITS+1 cycles later.
    @(negedge clk);
    a = 16'h1234; b = 16'h5678; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a = 16'h0050; b = 16'h0020; sub = 1'b1; cin = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done && cyc < 40);
    check("b2b.latency1", cyc, 4);
    check("b2b.result1", result, 16'h6912);
    cyc = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end while (!done && cyc < 40);
    check("b2b.spacing", cyc, 5);
    check("b2b.result2", result, 16'h0029);
    check("b2b.cout2", cout, 1);

    // Reset at the second RUN cycle aborts the operation with no done.
    @(negedge clk);
    a = 16'h4321; b = 16'h1111; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort.busy", busy, 0);
    check("abort.result", result, 0);
    check("abort.zero", zero, 1);
    check("abort.cout", cout, 0);
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("abort.no_done", dones, 0);

    sweep_go = 1'b1;
    guard = 0;
    while (!(sw[0].fin && sw[1].fin && sw[2].fin) && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    check("sweep.finished", (sw[0].fin && sw[1].fin && sw[2].fin), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
